// File: rtl/serial_cmp_pkg.sv
// rtl/serial_cmp_pkg.sv - shared FSM state type and default operand width for serial_eq_cmp
package serial_cmp_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bit_eq_cell.sv
// rtl/bit_eq_cell.sv - single-bit equality cell, high when both inputs match
module bit_eq_cell (
  input  logic a_i,
  input  logic b_i,
  output logic eq_o
);

  assign eq_o = ~(a_i ^ b_i);

endmodule

// File: rtl/serial_eq_cmp.sv
// rtl/serial_eq_cmp.sv - MSB-first serial comparator of two WIDTH-bit operands
// Define SERIAL_EQ_CMP_MAGNITUDE_EN to produce gt/lt; otherwise both are tied low.
module serial_eq_cmp
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       clear_i,
  input  logic                       bit_valid_i,
  input  logic                       a_bit_i,
  input  logic                       b_bit_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       eq_o,
  output logic                       gt_o,
  output logic                       lt_o,
  output logic [$clog2(WIDTH+1)-1:0] count_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

  state_e        state_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          eq_acc_q;
  logic          eq_q;
  logic          busy_q;
  logic          done_q;
  logic          bit_match;

  bit_eq_cell u_bit_eq (
    .a_i  (a_bit_i),
    .b_i  (b_bit_i),
    .eq_o (bit_match)
  );

  assign count_d = count_q + CW'(1);

`ifdef SERIAL_EQ_CMP_MAGNITUDE_EN
  logic gt_acc_q;
  logic lt_acc_q;
  logic gt_q;
  logic lt_q;
  logic first_diff;

  // Only the most significant differing bit decides the magnitude.
  assign first_diff = eq_acc_q & ~bit_match;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      count_q  <= '0;
      eq_acc_q <= 1'b0;
      eq_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_EQ_CMP_MAGNITUDE_EN
      gt_acc_q <= 1'b0;
      lt_acc_q <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
`endif
    end else if (clear_i) begin
      // Abort keeps the last completed result visible.
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q  <= SHIFT;
            busy_q   <= 1'b1;
            count_q  <= '0;
            eq_acc_q <= 1'b1;
`ifdef SERIAL_EQ_CMP_MAGNITUDE_EN
            gt_acc_q <= 1'b0;
            lt_acc_q <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (count_q == LAST_CNT) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            eq_q    <= eq_acc_q;
`ifdef SERIAL_EQ_CMP_MAGNITUDE_EN
            gt_q    <= gt_acc_q;
            lt_q    <= lt_acc_q;
`endif
          end else if (bit_valid_i) begin
            count_q  <= count_d;
            eq_acc_q <= eq_acc_q & bit_match;
`ifdef SERIAL_EQ_CMP_MAGNITUDE_EN
            if (first_diff) begin
              gt_acc_q <= a_bit_i & ~b_bit_i;
              lt_acc_q <= ~a_bit_i & b_bit_i;
            end
`endif
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign eq_o    = eq_q;
  assign count_o = count_q;

`ifdef SERIAL_EQ_CMP_MAGNITUDE_EN
  assign gt_o = gt_q;
  assign lt_o = lt_q;
`else
  assign gt_o = 1'b0;
  assign lt_o = 1'b0;
`endif

endmodule
